// File: rtl/alu_issue_stage.sv
// ----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage in front of the ALU. Decodes the RV32I opcode, funct3 and
// funct7 bit 30 into a 3-bit ALU operation and selects the two operands. The
// result is presented to execute from an output register (OR) backed by a
// single skid register (SK), so back-pressure never drops or bubbles an entry.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   flush              synchronous flush of OR and SK
//   in_valid/in_ready  upstream handshake (in_ready is the inverse of SK.valid)
//   opcode, funct3,    decoded instruction fields
//   funct7_b5
//   pc, rs1_data,      operand sources
//   rs2_data, imm
//   out_valid/out_ready downstream handshake toward execute
//   alu_control, a, b  ALU operation and operands
//   illegal            unsupported instruction flag (entry still propagates)
// ----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int WIDTH      = 32,
    parameter int CTRL_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b5,
    input  logic [WIDTH-1:0]      pc,
    input  logic [WIDTH-1:0]      rs1_data,
    input  logic [WIDTH-1:0]      rs2_data,
    input  logic [WIDTH-1:0]      imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] alu_control,
    output logic [WIDTH-1:0]      a,
    output logic [WIDTH-1:0]      b,
    output logic                  illegal
);

    localparam logic [CTRL_WIDTH-1:0] OP_ADD = 3'b000;
    localparam logic [CTRL_WIDTH-1:0] OP_SUB = 3'b001;
    localparam logic [CTRL_WIDTH-1:0] OP_AND = 3'b010;
    localparam logic [CTRL_WIDTH-1:0] OP_OR  = 3'b011;
    localparam logic [CTRL_WIDTH-1:0] OP_XOR = 3'b100;
    localparam logic [CTRL_WIDTH-1:0] OP_SLT = 3'b101;
    localparam logic [CTRL_WIDTH-1:0] OP_SLL = 3'b110;
    localparam logic [CTRL_WIDTH-1:0] OP_SRL = 3'b111;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic [CTRL_WIDTH-1:0] dec_ctrl;
    logic [WIDTH-1:0]      dec_a;
    logic [WIDTH-1:0]      dec_b;
    logic                  dec_ill;
    logic                  is_r;

    // Output register (OR) and skid register (SK)
    logic                  vld_p1;
    logic [CTRL_WIDTH-1:0] ctrl_p1;
    logic [WIDTH-1:0]      a_p1;
    logic [WIDTH-1:0]      b_p1;
    logic                  ill_p1;
    logic                  sk_vld_p1;
    logic [CTRL_WIDTH-1:0] sk_ctrl_p1;
    logic [WIDTH-1:0]      sk_a_p1;
    logic [WIDTH-1:0]      sk_b_p1;
    logic                  sk_ill_p1;

    logic in_xfer;
    logic or_free;

    assign is_r = (opcode == OPC_R);

    // ---- stage p0: combinational decode ----
    always_comb begin
        dec_ill  = 1'b0;
        dec_ctrl = OP_ADD;
        dec_a    = rs1_data;
        dec_b    = rs2_data;
        case (opcode)
            OPC_R, OPC_I: begin
                if (!is_r) dec_b = imm;
                case (funct3)
                    3'b000:  dec_ctrl = (is_r && funct7_b5) ? OP_SUB : OP_ADD;
                    3'b001:  dec_ctrl = OP_SLL;
                    3'b010:  dec_ctrl = OP_SLT;
                    3'b100:  dec_ctrl = OP_XOR;
                    3'b101: begin
                        // Arithmetic right shift has no ALU encoding
                        dec_ctrl = OP_SRL;
                        dec_ill  = funct7_b5;
                    end
                    3'b110:  dec_ctrl = OP_OR;
                    3'b111:  dec_ctrl = OP_AND;
                    default: dec_ill  = 1'b1;  // SLTU: no unsigned compare
                endcase
                if (is_r && funct7_b5 && funct3 != 3'b000 && funct3 != 3'b101)
                    dec_ill = 1'b1;
            end
            OPC_LOAD, OPC_STORE: dec_b = imm;
            OPC_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: dec_ctrl = OP_SUB;
                    3'b100, 3'b101: dec_ctrl = OP_SLT;
                    default:        dec_ill  = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = imm;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm;
            end
            OPC_JAL, OPC_JALR: begin
                dec_a = pc;
                dec_b = WIDTH'(4);
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries travel with a fixed, harmless payload
        if (dec_ill) begin
            dec_ctrl = OP_ADD;
            dec_a    = rs1_data;
            dec_b    = rs2_data;
        end
    end

    assign in_ready = ~sk_vld_p1;
    assign in_xfer  = in_valid & in_ready;
    // OR can take a new entry when empty or emptying this cycle
    assign or_free  = ~vld_p1 | out_ready;

    // ---- stage p1: output register plus skid register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            a_p1       <= '0;
            b_p1       <= '0;
            ill_p1     <= 1'b0;
            sk_vld_p1  <= 1'b0;
            sk_ctrl_p1 <= '0;
            sk_a_p1    <= '0;
            sk_b_p1    <= '0;
            sk_ill_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1    <= 1'b0;
            sk_vld_p1 <= 1'b0;
        end else if (or_free) begin
            if (sk_vld_p1) begin
                // SK is older than anything arriving; in_ready is low here
                vld_p1    <= 1'b1;
                ctrl_p1   <= sk_ctrl_p1;
                a_p1      <= sk_a_p1;
                b_p1      <= sk_b_p1;
                ill_p1    <= sk_ill_p1;
                sk_vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= in_xfer;
                if (in_xfer) begin
                    ctrl_p1 <= dec_ctrl;
                    a_p1    <= dec_a;
                    b_p1    <= dec_b;
                    ill_p1  <= dec_ill;
                end
            end
        end else if (in_xfer) begin
            sk_vld_p1  <= 1'b1;
            sk_ctrl_p1 <= dec_ctrl;
            sk_a_p1    <= dec_a;
            sk_b_p1    <= dec_b;
            sk_ill_p1  <= dec_ill;
        end
    end

    assign out_valid   = vld_p1;
    assign alu_control = ctrl_p1;
    assign a           = a_p1;
    assign b           = b_p1;
    assign illegal     = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_b5 = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;

    int total = 0;
    int bad = 0;
    ent_t q[$];

    alu_issue_stage #(.WIDTH(32), .CTRL_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_b5(funct7_b5),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_control(alu_control), .a(a), .b(b), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode from the instruction-set rules
    function automatic ent_t ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] pcv, input logic [31:0] r1,
                                     input logic [31:0] r2, input logic [31:0] im);
        ent_t e;
        bit   rt;
        e = '{ctrl: 3'd0, a: r1, b: r2, ill: 1'b0};
        rt = (op == 7'h33);
        if (op == 7'h33 || op == 7'h13) begin
            case (f3)
                3'd0: e.ctrl = (rt && f7) ? 3'd1 : 3'd0;
                3'd1: e.ctrl = 3'd6;
                3'd2: e.ctrl = 3'd5;
                3'd3: e.ill  = 1'b1;
                3'd4: e.ctrl = 3'd4;
                3'd5: begin e.ctrl = 3'd7; e.ill = f7; end
                3'd6: e.ctrl = 3'd3;
                default: e.ctrl = 3'd2;
            endcase
            if (rt && f7 && f3 != 3'd0 && f3 != 3'd5) e.ill = 1'b1;
            if (!rt) e.b = im;
        end else if (op == 7'h03 || op == 7'h23) e.b = im;
        else if (op == 7'h63) begin
            if (f3 == 3'd0 || f3 == 3'd1) e.ctrl = 3'd1;
            else if (f3 == 3'd4 || f3 == 3'd5) e.ctrl = 3'd5;
            else e.ill = 1'b1;
        end else if (op == 7'h37) begin e.a = 32'd0; e.b = im; end
        else if (op == 7'h17) begin e.a = pcv; e.b = im; end
        else if (op == 7'h6F || op == 7'h67) begin e.a = pcv; e.b = 32'd4; end
        else e.ill = 1'b1;
        if (e.ill) e = '{ctrl: 3'd0, a: r1, b: r2, ill: 1'b1};
        return e;
    endfunction

    // Compare at the falling edge, then advance the model at the rising edge
    task automatic cycle();
        bit   push, pop, fl;
        ent_t d;
        @(negedge clk);
        chk("in_ready", in_ready, (q.size() < 2));
        chk("out_valid", out_valid, (q.size() > 0));
        if (q.size() > 0) begin
            chk("alu_control", alu_control, q[0].ctrl);
            chk("a", a, q[0].a);
            chk("b", b, q[0].b);
            chk("illegal", illegal, q[0].ill);
        end
        fl   = flush;
        push = in_valid && (q.size() < 2);
        pop  = out_ready && (q.size() > 0);
        d    = ref_dec(opcode, funct3, funct7_b5, pc, rs1_data, rs2_data, imm);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] pcv);
        opcode = op; funct3 = f3; funct7_b5 = f7;
        rs1_data = r1; rs2_data = r2; imm = im; pc = pcv;
    endtask

    logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37,
                             7'h17, 7'h6F, 7'h67, 7'h33, 7'h13, 7'h7F};

    initial begin
        // Reset state
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst alu_control", alu_control, 0);
        chk("rst a", a, 0);
        chk("rst b", b, 0);
        chk("rst illegal", illegal, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // R-type SUB
        out_ready = 1'b1; in_valid = 1'b1;
        drive(7'h33, 3'd0, 1'b1, 32'h10, 32'h3, 32'h0, 32'h0);
        cycle();
        chk("sub out_valid", out_valid, 1);
        chk("sub alu_control", alu_control, 3'b001);
        chk("sub a", a, 32'h10);
        chk("sub b", b, 32'h3);
        chk("sub illegal", illegal, 0);

        // SLTI then JAL back to back
        drive(7'h13, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h77, 32'h5, 32'h0);
        cycle();
        chk("slti alu_control", alu_control, 3'b101);
        chk("slti a", a, 32'hFFFF_FFFF);
        chk("slti b", b, 32'h5);
        drive(7'h6F, 3'd0, 1'b0, 32'h1, 32'h2, 32'h3, 32'h100);
        cycle();
        chk("jal alu_control", alu_control, 3'b000);
        chk("jal a", a, 32'h100);
        chk("jal b", b, 32'h4);

        // Illegal: SRAI, SLTU, opcode 0x7F
        drive(7'h13, 3'd5, 1'b1, 32'hAA, 32'hBB, 32'hCC, 32'h0);
        cycle();
        chk("srai illegal", illegal, 1);
        chk("srai alu_control", alu_control, 0);
        chk("srai b", b, 32'hBB);
        drive(7'h33, 3'd3, 1'b0, 32'h11, 32'h22, 32'h33, 32'h0);
        cycle();
        chk("sltu illegal", illegal, 1);
        drive(7'h7F, 3'd0, 1'b0, 32'h44, 32'h55, 32'h66, 32'h0);
        cycle();
        chk("op7f illegal", illegal, 1);
        chk("op7f a", a, 32'h44);
        in_valid = 1'b0;
        cycle();

        // Back-pressure: ADD, AND, OR with execute stalled
        out_ready = 1'b0; in_valid = 1'b1;
        drive(7'h33, 3'd0, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0);
        cycle();
        drive(7'h33, 3'd7, 1'b0, 32'h3, 32'h4, 32'h0, 32'h0);
        cycle();
        drive(7'h33, 3'd6, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0);
        chk("bp in_ready low", in_ready, 0);
        cycle();
        cycle();
        chk("bp hold ctrl", alu_control, 3'b000);
        chk("bp hold a", a, 32'h1);
        out_ready = 1'b1;
        cycle();
        chk("bp second AND", alu_control, 3'b010);
        cycle();
        chk("bp third OR", alu_control, 3'b011);
        in_valid = 1'b0;
        cycle();
        chk("bp drained", out_valid, 0);

        // Flush with OR and SK full plus an incoming entry
        out_ready = 1'b0; in_valid = 1'b1;
        cycle(); cycle();
        drive(7'h13, 3'd4, 1'b0, 32'h9, 32'h9, 32'h9, 32'h0);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        out_ready = 1'b1;
        cycle(); cycle();

        // Reset asserted mid-stall with a transfer pending
        out_ready = 1'b0; in_valid = 1'b1;
        cycle(); cycle();
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst in_ready", in_ready, 1);
        chk("mid rst alu_control", alu_control, 0);
        chk("mid rst a", a, 0);
        chk("mid rst b", b, 0);
        q.delete();
        in_valid = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            opcode    = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 11)];
            funct3    = 3'($urandom);
            funct7_b5 = 1'($urandom);
            pc        = $urandom;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            imm       = $urandom;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle(); cycle(); cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces everything the ALU consumes: the 3-bit ALU operation code plus the two operands.
- Accepts decoded RV32I instruction fields and register-file read data over a valid/ready handshake.
- Translates them into ALU control and operand selection, then presents them to the execute stage through a registered output with a 2-entry skid buffer.
- Sits between the register-file read stage and the ALU; back-pressure from execute stalls decode without bubbles or loss.

Parameters:
WIDTH, 32, operand/data width
CTRL_WIDTH, 3, ALU control width (fixed encoding below)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
flush  input  1  synchronous pipeline flush
in_valid  input  1  upstream fields valid
in_ready  output  1  stage can accept this cycle
opcode  input  7  instruction opcode [6:0]
funct3  input  3  instruction funct3
funct7_b5  input  1  instruction bit 30
pc  input  WIDTH  instruction address
rs1_data  input  WIDTH  register source 1
rs2_data  input  WIDTH  register source 2
imm  input  WIDTH  sign-extended immediate
out_valid  output  1  ALU inputs valid
out_ready  input  1  execute stage accepts
alu_control  output  CTRL_WIDTH  ALU op code
a  output  WIDTH  ALU operand a
b  output  WIDTH  ALU operand b
illegal  output  1  unsupported instruction flag

Behaviour:
- ALU encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.

Decode for R-type (0110011) and I-type (0010011), by funct3:
- 000: ADD; SUB only when R-type and funct7_b5=1.
- 001: SLL.
- 010: SLT.
- 100: XOR.
- 101: SRL; funct7_b5=1 is SRA and is illegal.
- 110: OR.
- 111: AND.
- 011 (SLTU): illegal.
- R-type with funct7_b5=1 and funct3 not in {000,101}: illegal.

Decode for other opcodes:
- Load (0000011), store (0100011): ADD, a=rs1, b=imm.
- Branch (1100011): funct3 000/001 → SUB; 100/101 → SLT; all others illegal. a=rs1, b=rs2.
- LUI (0110111): ADD, a=0, b=imm.
- AUIPC (0010111): ADD, a=pc, b=imm.
- JAL (1101111), JALR (1100111): ADD, a=pc, b=4.
- R-type operands: a=rs1, b=rs2. I-type operands: a=rs1, b=imm.
- Any other opcode: illegal.
- Illegal entries still propagate, with alu_control=000, a=rs1, b=rs2, illegal=1.

Handshake and buffering:
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Output register (OR) plus one skid register (SK).
- in_ready is registered and equals !SK.valid.
- Accept while OR empty, or OR draining this cycle: decoded entry → OR next cycle.
- Accept while OR full and not draining: entry → SK.
- OR drains while SK full: SK → OR, SK empties, in_ready rises next cycle.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Throughput: 1/cycle with out_ready held high.
- While out_valid=1 and out_ready=0, alu_control/a/b/illegal are held stable.
- Ordering is strictly FIFO; no entry is dropped or duplicated.

Flush:
- Next edge clears OR.valid and SK.valid; in_ready=1.
- An input transfer in the same cycle as flush is discarded; flush wins.
- An output transfer in the flush cycle still completes.

Reset (rst_n low, async):
- out_valid=0, alu_control=0, a=0, b=0, illegal=0, SK cleared.
- in_ready=1 after release; data registers zero.
- Reset mid-stall drops all held entries.

Test Plan:
- Reset asserted mid-transfer → out_valid=0, in_ready=1, alu_control=000, a=b=0 immediately (async).
- R-type SUB: opcode=0110011, funct3=000, funct7_b5=1, rs1=0x10, rs2=0x3 → one cycle later out_valid=1, alu_control=001, a=0x10, b=0x3, illegal=0.
- I-type SLTI: opcode=0010011, funct3=010, rs1=0xFFFFFFFF, imm=0x5 → alu_control=101, b=0x5; JAL with pc=0x100 → alu_control=000, a=0x100, b=4.
- Back-pressure: out_ready=0, three back-to-back ADD/AND/OR → OR holds ADD, SK holds AND, in_ready=0 on cycle 3, OR not accepted. Raise out_ready → ADD, AND, OR emerge in order on consecutive cycles.
- Illegal SRAI/SLTU/opcode 0x7F → illegal=1, alu_control=000, still handshaked.
- Flush with OR and SK full plus simultaneous in_valid → next cycle out_valid=0, in_ready=1; the incoming entry never appears.
